// File: rtl/fwd_ctrl.sv
// Operand-forwarding and load-use hazard controller for the 5-stage pipeline.
// Tracks EX/MEM/WB producers and drives the ALU operand mux selects and stall.
module fwd_ctrl #(
    parameter int REG_BITS = 5,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic                id_imm_b,
    input  logic                id_wr_en,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_is_load,
    input  logic                flush,
    output logic                stall,
    output logic [1:0]          fwd_a_sel,
    output logic [1:0]          fwd_b_sel,
    output logic                ex_bubble,
    output logic [CNT_BITS-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        SEL_RF    = 2'b00,
        SEL_EXMEM = 2'b01,
        SEL_MEMWB = 2'b10,
        SEL_IMM   = 2'b11
    } sel_e;

    typedef struct packed {
        logic                valid;
        logic                wr;
        logic [REG_BITS-1:0] rd;
        logic                load;
    } stage_t;

    localparam int EX  = 0;
    localparam int MEM = 1;
    localparam int WB  = 2;

    stage_t stage_q [3];

    logic   rs_hit_ex;
    logic   rt_hit_ex;
    logic   rt_needed;
    logic   load_use;
    logic   advance;
    sel_e   a_sel_d;
    sel_e   b_sel_d;
    stage_t id_rec;

    // Register 0 is hardwired, so a write to it is never a real producer.
    function automatic logic writes(input logic v, input logic w,
                                    input logic [REG_BITS-1:0] rd,
                                    input logic [REG_BITS-1:0] r);
        return v && w && (rd == r) && (r != '0);
    endfunction

    assign stall = !rst && id_valid && !flush && load_use;

    always_comb begin
        rt_needed = id_use_rt && !id_imm_b;
        rs_hit_ex = id_use_rs && writes(stage_q[EX].valid, stage_q[EX].wr,
                                        stage_q[EX].rd, id_rs);
        rt_hit_ex = rt_needed && writes(stage_q[EX].valid, stage_q[EX].wr,
                                        stage_q[EX].rd, id_rt);
        load_use  = stage_q[EX].load && (rs_hit_ex || rt_hit_ex);
        advance   = id_valid && !flush && !stall;

        id_rec.valid = 1'b1;
        id_rec.wr    = id_wr_en;
        id_rec.rd    = id_rd;
        id_rec.load  = id_is_load;
    end

    // The newest producer wins: the EX record is checked before the MEM record.
    always_comb begin
        a_sel_d = SEL_RF;
        if (id_use_rs) begin
            if (writes(stage_q[EX].valid, stage_q[EX].wr, stage_q[EX].rd, id_rs))
                a_sel_d = SEL_EXMEM;
            else if (writes(stage_q[MEM].valid, stage_q[MEM].wr, stage_q[MEM].rd, id_rs))
                a_sel_d = SEL_MEMWB;
        end

        b_sel_d = SEL_RF;
        if (id_imm_b) begin
            b_sel_d = SEL_IMM;
        end else if (id_use_rt) begin
            if (writes(stage_q[EX].valid, stage_q[EX].wr, stage_q[EX].rd, id_rt))
                b_sel_d = SEL_EXMEM;
            else if (writes(stage_q[MEM].valid, stage_q[MEM].wr, stage_q[MEM].rd, id_rt))
                b_sel_d = SEL_MEMWB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q[EX]  <= '0;
            stage_q[MEM] <= '0;
            stage_q[WB]  <= '0;
            fwd_a_sel    <= SEL_RF;
            fwd_b_sel    <= SEL_RF;
            ex_bubble    <= 1'b1;
        end else begin
            stage_q[WB]  <= stage_q[MEM];
            stage_q[MEM] <= stage_q[EX];
            if (advance) begin
                stage_q[EX] <= id_rec;
                fwd_a_sel   <= a_sel_d;
                fwd_b_sel   <= b_sel_d;
                ex_bubble   <= 1'b0;
            end else begin
                stage_q[EX] <= '0;
                fwd_a_sel   <= SEL_RF;
                fwd_b_sel   <= SEL_RF;
                ex_bubble   <= 1'b1;
            end
        end
    end

    // Saturating performance counter of stalled cycles.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_BITS'(1);
    end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed self-checking bench for fwd_ctrl: forwarding selects, load-use
// stalls, register-0 handling, flush priority, counter saturation and reset.
module tb_fwd_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_imm_b;
    logic        id_wr_en;
    logic [4:0]  id_rd;
    logic        id_is_load;
    logic        flush;
    logic        stall;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        ex_bubble;
    logic [15:0] stall_cnt;

    int tests;
    int errors;

    fwd_ctrl #(.REG_BITS(5), .CNT_BITS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_imm_b   (id_imm_b),
        .id_wr_en   (id_wr_en),
        .id_rd      (id_rd),
        .id_is_load (id_is_load),
        .flush      (flush),
        .stall      (stall),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel),
        .ex_bubble  (ex_bubble),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid   = 1'b0;
        id_rs      = '0;
        id_rt      = '0;
        id_use_rs  = 1'b0;
        id_use_rt  = 1'b0;
        id_imm_b   = 1'b0;
        id_wr_en   = 1'b0;
        id_rd      = '0;
        id_is_load = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic present(input logic [4:0] rs, input logic urs,
                           input logic [4:0] rt, input logic urt,
                           input logic imm, input logic wr,
                           input logic [4:0] rd, input logic ld);
        id_valid   = 1'b1;
        id_rs      = rs;
        id_use_rs  = urs;
        id_rt      = rt;
        id_use_rt  = urt;
        id_imm_b   = imm;
        id_wr_en   = wr;
        id_rd      = rd;
        id_is_load = ld;
        flush      = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        tests++;
        if (fwd_a_sel !== 2'b00) begin
            $display("[TB] FAIL reset_a_sel: got %b expected 00", fwd_a_sel);
            errors++;
        end
        tests++;
        if (fwd_b_sel !== 2'b00) begin
            $display("[TB] FAIL reset_b_sel: got %b expected 00", fwd_b_sel);
            errors++;
        end
        tests++;
        if (ex_bubble !== 1'b1) begin
            $display("[TB] FAIL reset_bubble: got %b expected 1", ex_bubble);
            errors++;
        end
        tests++;
        if (stall_cnt !== 16'h0000) begin
            $display("[TB] FAIL reset_cnt: got %h expected 0000", stall_cnt);
            errors++;
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ex_forward();
        present(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0);
        tick();
        present(5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0);
        #1;
        tests++;
        if (stall !== 1'b0) begin
            $display("[TB] FAIL ex_fwd_stall: got %b expected 0", stall);
            errors++;
        end
        tick();
        tests++;
        if (fwd_a_sel !== 2'b01) begin
            $display("[TB] FAIL ex_fwd_a: got %b expected 01", fwd_a_sel);
            errors++;
        end
        tests++;
        if (fwd_b_sel !== 2'b00) begin
            $display("[TB] FAIL ex_fwd_b: got %b expected 00", fwd_b_sel);
            errors++;
        end
        tests++;
        if (ex_bubble !== 1'b0) begin
            $display("[TB] FAIL ex_fwd_bubble: got %b expected 0", ex_bubble);
            errors++;
        end
        drain();
    endtask

    task automatic test_mem_forward();
        present(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
        tick();
        present(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0);
        tick();
        present(5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0);
        tick();
        tests++;
        if (fwd_b_sel !== 2'b10) begin
            $display("[TB] FAIL mem_fwd_b: got %b expected 10", fwd_b_sel);
            errors++;
        end
        tests++;
        if (fwd_a_sel !== 2'b00) begin
            $display("[TB] FAIL mem_fwd_a: got %b expected 00", fwd_a_sel);
            errors++;
        end
        drain();
        present(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
        tick();
        present(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0);
        tick();
        present(5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);
        tick();
        tests++;
        if (fwd_b_sel !== 2'b11) begin
            $display("[TB] FAIL imm_b_sel: got %b expected 11", fwd_b_sel);
            errors++;
        end
        drain();
    endtask

    task automatic test_load_use();
        present(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1);
        tick();
        present(5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
        #1;
        tests++;
        if (stall !== 1'b1) begin
            $display("[TB] FAIL lu_stall_on: got %b expected 1", stall);
            errors++;
        end
        tick();
        tests++;
        if (ex_bubble !== 1'b1) begin
            $display("[TB] FAIL lu_bubble: got %b expected 1", ex_bubble);
            errors++;
        end
        tests++;
        if (fwd_a_sel !== 2'b00) begin
            $display("[TB] FAIL lu_bubble_a: got %b expected 00", fwd_a_sel);
            errors++;
        end
        tests++;
        if (stall !== 1'b0) begin
            $display("[TB] FAIL lu_stall_off: got %b expected 0", stall);
            errors++;
        end
        tick();
        tests++;
        if (fwd_a_sel !== 2'b10) begin
            $display("[TB] FAIL lu_fwd_a: got %b expected 10", fwd_a_sel);
            errors++;
        end
        tests++;
        if (ex_bubble !== 1'b0) begin
            $display("[TB] FAIL lu_reader_bubble: got %b expected 0", ex_bubble);
            errors++;
        end
        tests++;
        if (stall_cnt !== 16'd1) begin
            $display("[TB] FAIL lu_cnt: got %0d expected 1", stall_cnt);
            errors++;
        end
        drain();
    endtask

    task automatic test_reg_zero();
        present(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0);
        tick();
        present(5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0);
        tick();
        tests++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
            $display("[TB] FAIL r0_alu_sel: got %b expected 0000", {fwd_a_sel, fwd_b_sel});
            errors++;
        end
        drain();
        present(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1);
        tick();
        present(5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0);
        #1;
        tests++;
        if (stall !== 1'b0) begin
            $display("[TB] FAIL r0_load_stall: got %b expected 0", stall);
            errors++;
        end
        tick();
        tests++;
        if ({fwd_a_sel, fwd_b_sel, ex_bubble} !== 5'b00000) begin
            $display("[TB] FAIL r0_load_sel: got %b expected 00000",
                     {fwd_a_sel, fwd_b_sel, ex_bubble});
            errors++;
        end
        drain();
    endtask

    task automatic test_back_to_back();
        present(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0);
        tick();
        present(5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0);
        tick();
        present(5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0);
        tick();
        tests++;
        if (fwd_a_sel !== 2'b01) begin
            $display("[TB] FAIL b2b_newest_a: got %b expected 01", fwd_a_sel);
            errors++;
        end
        tests++;
        if (fwd_b_sel !== 2'b01) begin
            $display("[TB] FAIL b2b_newest_b: got %b expected 01", fwd_b_sel);
            errors++;
        end
        drain();
    endtask

    task automatic test_flush();
        present(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1);
        tick();
        present(5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd11, 1'b0);
        flush = 1'b1;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            $display("[TB] FAIL flush_stall: got %b expected 0", stall);
            errors++;
        end
        tick();
        tests++;
        if (ex_bubble !== 1'b1) begin
            $display("[TB] FAIL flush_bubble: got %b expected 1", ex_bubble);
            errors++;
        end
        tests++;
        if (stall_cnt !== 16'd1) begin
            $display("[TB] FAIL flush_cnt: got %0d expected 1", stall_cnt);
            errors++;
        end
        drain();
    endtask

    task automatic test_saturation();
        force dut.stall = 1'b1;
        repeat (65540) tick();
        tests++;
        if (stall_cnt !== 16'hFFFF) begin
            $display("[TB] FAIL sat_cnt: got %h expected ffff", stall_cnt);
            errors++;
        end
        release dut.stall;
        drain();
        tests++;
        if (stall_cnt !== 16'hFFFF) begin
            $display("[TB] FAIL sat_hold: got %h expected ffff", stall_cnt);
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        present(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd11, 1'b0);
        tick();
        present(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd12, 1'b0);
        tick();
        present(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd13, 1'b1);
        tick();
        rst = 1'b1;
        present(5'd13, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1, 5'd14, 1'b0);
        #1;
        tests++;
        if (stall !== 1'b0) begin
            $display("[TB] FAIL rst_stall: got %b expected 0", stall);
            errors++;
        end
        tick();
        tests++;
        if (stall_cnt !== 16'h0000) begin
            $display("[TB] FAIL rst_mid_cnt: got %h expected 0000", stall_cnt);
            errors++;
        end
        tests++;
        if (ex_bubble !== 1'b1) begin
            $display("[TB] FAIL rst_mid_bubble: got %b expected 1", ex_bubble);
            errors++;
        end
        rst = 1'b0;
        present(5'd13, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1, 5'd14, 1'b0);
        #1;
        tests++;
        if (stall !== 1'b0) begin
            $display("[TB] FAIL rst_reader_stall: got %b expected 0", stall);
            errors++;
        end
        tick();
        tests++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
            $display("[TB] FAIL rst_reader_sel: got %b expected 0000", {fwd_a_sel, fwd_b_sel});
            errors++;
        end
        tests++;
        if (stall_cnt !== 16'h0000) begin
            $display("[TB] FAIL rst_reader_cnt: got %h expected 0000", stall_cnt);
            errors++;
        end
        drain();
    endtask

    initial begin
        tests  = 0;
        errors = 0;
        rst    = 1'b1;
        idle();
        test_reset();
        test_ex_forward();
        test_mem_forward();
        test_load_use();
        test_reg_zero();
        test_back_to_back();
        test_flush();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
